demux4b_buf: RTL and testbench

DEMUX4B_BUF -- requirements
Module: demux4b_buf

---
 rtl/demux4b_buf_if.sv | 21 ++
 rtl/demux4b_buf.sv | 68 ++++++
 tb/tb_demux4b_buf.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/demux4b_buf_if.sv
// demux4b_buf_if: nibble source and two-channel sink handshake bundle
interface demux4b_buf_if;
  logic       s;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out1_valid;
  logic [3:0] out1_data;
  logic       out1_ready;
  logic       out2_valid;
  logic [3:0] out2_data;
  logic       out2_ready;
  modport master (
    output s, in_valid, in_data, out1_ready, out2_ready,
    input  in_ready, out1_valid, out1_data, out2_valid, out2_data
  );
  modport slave (
    input  s, in_valid, in_data, out1_ready, out2_ready,
    output in_ready, out1_valid, out1_data, out2_valid, out2_data
  );
endinterface

// File: rtl/demux4b_buf.sv
// demux4b_buf: 1-to-2 nibble demux with a DEPTH-entry FIFO per channel.
// Define DEMUX4B_CNT_EN to add saturating delivered counters cnt1/cnt2.
module demux4b_buf #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef DEMUX4B_CNT_EN
  output logic [7:0] cnt1,
  output logic [7:0] cnt2,
`endif
  demux4b_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] full, push, pop, ovalid, oready;
  logic [7:0] odata;
`ifdef DEMUX4B_CNT_EN
  logic [15:0] dcnt;
  assign cnt1 = dcnt[7:0];
  assign cnt2 = dcnt[15:8];
`endif
  assign oready         = {bus.out2_ready, bus.out1_ready};
  assign bus.in_ready   = bus.s ? !full[0] : !full[1];
  assign bus.out1_valid = ovalid[0];
  assign bus.out2_valid = ovalid[1];
  assign bus.out1_data  = odata[3:0];
  assign bus.out2_data  = odata[7:4];
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp, rp_n;
    logic [AW:0]   cnt;
    logic [3:0]    head, head_n;
    logic          sel;
    assign sel       = (c == 0) ? bus.s : !bus.s;
    assign full[c]   = cnt == (AW+1)'(DEPTH);
    assign ovalid[c] = cnt != '0;
    assign push[c]   = bus.in_valid && bus.in_ready && sel;
    assign pop[c]    = ovalid[c] && oready[c];
    assign rp_n      = rp + 1'b1;
    assign odata[c*4 +: 4] = head;
    // Head is registered: after a pop it comes from storage, or straight from
    // the input when the pop empties the channel while a new nibble arrives.
    always_comb
      head_n = pop[c] ? ((cnt > (AW+1)'(1)) ? mem[rp_n] : (push[c] ? bus.in_data : head))
                      : ((push[c] && cnt == '0) ? bus.in_data : head);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wp   <= '0;
        rp   <= '0;
        cnt  <= '0;
        head <= '0;
      end else begin
        if (push[c]) wp <= wp + 1'b1;
        if (pop[c]) rp <= rp_n;
        cnt  <= cnt + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
        head <= head_n;
      end
    always_ff @(posedge clk)
      if (push[c]) mem[wp] <= bus.in_data;
`ifdef DEMUX4B_CNT_EN
    logic [7:0] dc;
    assign dcnt[c*8 +: 8] = dc;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dc <= '0;
      else if (pop[c] && dc != 8'hFF) dc <= dc + 8'd1;
`endif
  end
endmodule

// File: tb/tb_demux4b_buf.sv
// tb_demux4b_buf: scoreboard bench for demux4b_buf at DEPTH=2 and DEPTH=4
module tb_demux4b_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  demux4b_buf_if b2();
  demux4b_buf_if b4();
`ifdef DEMUX4B_CNT_EN
  logic [7:0] c21, c22, c41, c42;
`endif
  demux4b_buf #(.DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef DEMUX4B_CNT_EN
    .cnt1(c21), .cnt2(c22),
`endif
    .bus(b2.slave)
  );
  demux4b_buf #(.DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef DEMUX4B_CNT_EN
    .cnt1(c41), .cnt2(c42),
`endif
    .bus(b4.slave)
  );
  int total = 0;
  int bad = 0;
  logic [3:0] q21[$], q22[$], q41[$], q42[$];
  int w;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic unexp(input string name, input logic [3:0] d);
    total++;
    bad++;
    $display("FAIL %s: got pop of %0h want no pop", name, d);
  endtask
  // Monitor: every handshake seen before an edge must match the queue head
  always @(negedge clk) begin
    if (b2.out1_valid && b2.out1_ready)
      if (q21.size() == 0) unexp("u2 ch1 pop", b2.out1_data); else chk("u2 ch1 order", 32'(b2.out1_data), 32'(q21.pop_front()));
    if (b2.out2_valid && b2.out2_ready)
      if (q22.size() == 0) unexp("u2 ch2 pop", b2.out2_data); else chk("u2 ch2 order", 32'(b2.out2_data), 32'(q22.pop_front()));
    if (b4.out1_valid && b4.out1_ready)
      if (q41.size() == 0) unexp("u4 ch1 pop", b4.out1_data); else chk("u4 ch1 order", 32'(b4.out1_data), 32'(q41.pop_front()));
    if (b4.out2_valid && b4.out2_ready)
      if (q42.size() == 0) unexp("u4 ch2 pop", b4.out2_data); else chk("u4 ch2 order", 32'(b4.out2_data), 32'(q42.pop_front()));
  end
  task automatic push2(input logic sel, input logic [3:0] d, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    b2.s = sel;
    b2.in_data = d;
    b2.in_valid = 1'b1;
    while (!acc && waits < 50) begin
      @(negedge clk);
      if (b2.in_ready) acc = 1'b1; else waits++;
    end
    if (acc) begin
      if (sel) q21.push_back(d); else q22.push_back(d);
    end else begin
      chk("u2 push timeout", 32'(acc), 1);
    end
    @(posedge clk);
    #1 b2.in_valid = 1'b0;
  endtask
  task automatic push4(input logic sel, input logic [3:0] d);
    logic acc;
    int waits;
    acc = 1'b0;
    waits = 0;
    b4.s = sel;
    b4.in_data = d;
    b4.in_valid = 1'b1;
    while (!acc && waits < 50) begin
      @(negedge clk);
      if (b4.in_ready) acc = 1'b1; else waits++;
    end
    if (acc) begin
      if (sel) q41.push_back(d); else q42.push_back(d);
    end else begin
      chk("u4 push timeout", 32'(acc), 1);
    end
    @(posedge clk);
    #1 b4.in_valid = 1'b0;
  endtask
  task automatic drain2(input logic ch);
    int n;
    if (ch) b2.out1_ready = 1'b1; else b2.out2_ready = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!(ch ? b2.out1_valid : b2.out2_valid)) break;
    end
    if (n == 50) chk("u2 drain timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    b2.out1_ready = 1'b0;
    b2.out2_ready = 1'b0;
  endtask
  task automatic drain4();
    int n;
    b4.out1_ready = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!b4.out1_valid) break;
    end
    if (n == 50) chk("u4 drain timeout", 32'(n), 0);
    @(posedge clk);
    #1 b4.out1_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    {b2.s, b2.in_valid, b2.in_data, b2.out1_ready, b2.out2_ready} = '0;
    {b4.s, b4.in_valid, b4.in_data, b4.out1_ready, b4.out2_ready} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(b2.in_ready), 1);
    chk("rst out1_valid", 32'(b2.out1_valid), 0);
    chk("rst out2_valid", 32'(b2.out2_valid), 0);
    chk("rst out1_data", 32'(b2.out1_data), 0);
    chk("rst out2_data", 32'(b2.out2_data), 0);
    chk("rst u4 in_ready", 32'(b4.in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // single push appears the cycle after the edge
    push2(1'b1, 4'hA, w);
    chk("push1 out1_valid", 32'(b2.out1_valid), 1);
    chk("push1 out1_data", 32'(b2.out1_data), 32'hA);
    chk("push1 out2_valid", 32'(b2.out2_valid), 0);
    drain2(1'b1);
    // fill channel 2, hold a third nibble until space frees
    push2(1'b0, 4'h3, w);
    push2(1'b0, 4'h5, w);
    chk("full in_ready", 32'(b2.in_ready), 0);
    chk("full head", 32'(b2.out2_data), 32'h3);
    b2.out2_ready = 1'b1;
    push2(1'b0, 4'h7, w);
    chk("held push wait", 32'(w), 1);
    drain2(1'b0);
    // channel 1 full, switching s reopens in_ready in the same cycle
    push2(1'b1, 4'h1, w);
    push2(1'b1, 4'h2, w);
    chk("ch1 full in_ready", 32'(b2.in_ready), 0);
    b2.s = 1'b0;
    #1;
    chk("s switch in_ready", 32'(b2.in_ready), 1);
    push2(1'b0, 4'h9, w);
    chk("s switch out2_valid", 32'(b2.out2_valid), 1);
    chk("s switch out2_data", 32'(b2.out2_data), 32'h9);
    chk("s switch out1_data", 32'(b2.out1_data), 32'h1);
    push2(1'b0, 4'h4, w);
    b2.s = 1'b1;
    #1;
    chk("ch1 still full", 32'(b2.in_ready), 0);
    // asynchronous reset with two entries buffered in each channel
    #2 rst_n = 1'b0;
    #1;
    chk("async out1_valid", 32'(b2.out1_valid), 0);
    chk("async out2_valid", 32'(b2.out2_valid), 0);
    chk("async in_ready", 32'(b2.in_ready), 1);
    chk("async out1_data", 32'(b2.out1_data), 0);
    chk("async out2_data", 32'(b2.out2_data), 0);
    q21.delete();
    q22.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push2(1'b1, 4'hE, w);
    chk("post rst head", 32'(b2.out1_data), 32'hE);
    drain2(1'b1);
    chk("post rst out2_valid", 32'(b2.out2_valid), 0);
    // both channels pop in the same cycle
    push2(1'b1, 4'h6, w);
    push2(1'b0, 4'hC, w);
    b2.out1_ready = 1'b1;
    b2.out2_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("dual pop out1_valid", 32'(b2.out1_valid), 0);
    chk("dual pop out2_valid", 32'(b2.out2_valid), 0);
    b2.out1_ready = 1'b0;
    b2.out2_ready = 1'b0;
    // DEPTH=4 streaming with wrap, then a fill to full
    b4.out1_ready = 1'b1;
    for (int i = 0; i < 10; i++) push4(1'b1, 4'(i));
    drain4();
    for (int i = 0; i < 4; i++) push4(1'b1, 4'hB + 4'(i));
    chk("u4 full in_ready", 32'(b4.in_ready), 0);
    chk("u4 full head", 32'(b4.out1_data), 32'hB);
    drain4();
    chk("u4 out2_valid", 32'(b4.out2_valid), 0);
`ifdef DEMUX4B_CNT_EN
    #2 rst_n = 1'b0;
    #1;
    chk("cnt1 reset", 32'(c21), 0);
    chk("cnt2 reset", 32'(c22), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    b2.out2_ready = 1'b1;
    for (int i = 0; i < 300; i++) push2(1'b0, 4'(i), w);
    drain2(1'b0);
    chk("cnt2 saturate", 32'(c22), 255);
    chk("cnt1 idle", 32'(c21), 0);
`endif
    chk("scoreboard empty", 32'(q21.size() + q22.size() + q41.size() + q42.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
